serdes_tx_serializer: RTL and testbench
=======================================

Name: serdes_tx_serializer

Overview:
Parallel-to-serial transmitter. It is the transmit end of the serdes link, whose receiver captures DATA_W bits LSB-first, one bit per clock, on a single wire.
- Accepts bytes through a valid/ready handshake into a small FIFO.
- Shifts each byte out LSB-first, one bit per clk, with an optional even-parity bit.
- Marks the first bit of each frame with a strobe.
- Sits between core logic and the uo_out serial pin of the serdes top.

Parameters:
- DATA_W, 8: bits per frame.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of two and at least 2.
- PARITY_EN, 1: when 1, an even-parity bit is appended after the data bits.
- IDLE_LEVEL, 0: tx_out level while no frame is in progress.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  shift enable; low freezes the shifter.
- s_data  in  DATA_W  byte to transmit.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a byte.
- tx_out  out  1  serial data, registered.
- tx_frame  out  1  high only during the first data bit of a frame.
- tx_active  out  1  high while a data or parity bit is on tx_out.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empties; fifo_count=0; s_ready=1.
  - FSM goes to IDLE; tx_out=IDLE_LEVEL; tx_frame=0; tx_active=0.
  - A reset mid-frame aborts the frame with no partial completion.
- Write side:
  - A write occurs when s_valid&&s_ready at a clk edge.
  - s_ready = (fifo_count != FIFO_DEPTH), computed from registered count.
  - When the FIFO is full, s_ready is low even if a pop occurs in the same cycle.
  - Writes are accepted regardless of ena.
- Pop side:
  - The FSM pops the FIFO head and loads the shift register at the same edge.
  - Pop plus write in one edge leaves fifo_count unchanged.
- FSM states: IDLE, DATA, PARITY.
  - IDLE: if ena && fifo_count!=0, pop and load. At that edge set tx_out=data[0], tx_frame=1, tx_active=1, bit_cnt=1, and go to DATA.
  - DATA, each enabled edge:
    - If bit_cnt<DATA_W: tx_out=next bit and bit_cnt++.
    - If bit_cnt==DATA_W and PARITY_EN: tx_out = XOR of all data bits (even parity), go to PARITY.
    - If bit_cnt==DATA_W and !PARITY_EN: take the end-of-frame decision below.
  - PARITY, on the enabled edge: take the end-of-frame decision.
  - End-of-frame decision:
    - FIFO non-empty: pop immediately and start the next frame with no gap cycle (tx_frame=1 again).
    - FIFO empty: go to IDLE; tx_out=IDLE_LEVEL; tx_active=0.
  - tx_frame is 0 on every edge that does not launch a first bit.
- ena=0:
  - No pop, no shift, no state or bit_cnt change.
  - tx_out, tx_frame and tx_active hold their values (tx_frame held means a repeated strobe is possible; the receiver qualifies with ena).
- Latency:
  - Byte written at edge N into an empty FIFO with ena=1: data[0] appears after edge N+1 and data[i] after edge N+1+i.
  - With PARITY_EN=1, parity appears after edge N+1+DATA_W.
- Frame length: DATA_W+PARITY_EN clocks. Sustained throughput is one byte per frame length while the FIFO stays non-empty.
- Pointers wrap modulo FIFO_DEPTH; fifo_count saturates nowhere (writes are blocked when full, pops are blocked when empty).

Decomposition:
- serdes_pkg holds:
  - the tx FSM state enum (IDLE, DATA, PARITY);
  - the DATA_W default constant;
  - the default IDLE_LEVEL constant.
- One sub-module: serdes_tx_fifo, a synchronous FIFO with push, pop, full, empty and count outputs, parameterised on DATA_W and FIFO_DEPTH.
- The FSM and shift register stay in serdes_tx_serializer.

Test Plan:
- Reset, ena=1, write 0xFF at edge N:
  - tx_out = 1 for edges N+1..N+8, parity 0 at N+9, IDLE_LEVEL at N+10.
  - tx_frame=1 only after N+1.
- Write 0xA5:
  - Serial sequence 1,0,1,0,0,1,0,1 then parity 0.
  - tx_active high for exactly 9 clocks.
- Back-to-back writes of 0x01 then 0x80:
  - Sequence 1,0,0,0,0,0,0,0,p=1, then 0,0,0,0,0,0,0,1,p=1.
  - No idle cycle between frames; tx_frame pulses twice, 9 clocks apart.
- ena=0, write 0x11,0x22,0x33,0x44:
  - fifo_count=4 and s_ready=0; a fifth s_valid is not accepted.
  - After ena=1, four frames go out in order and fifo_count returns to 0.
- Drop ena for 3 cycles after the 4th bit of 0xA5:
  - tx_out holds bit 3 (0) for the frozen cycles.
  - The frame then resumes with bit 4 and completes correctly.
- Assert rst_n=0 mid-frame:
  - tx_out=IDLE_LEVEL, tx_active=0, fifo_count=0 immediately, without waiting for clk.
  - After release, a new write of 0x3C transmits cleanly.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared definitions for the serdes transmit path.
package serdes_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam logic        IDLE_LEVEL_DEF = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } tx_state_t;

endpackage

// File: rtl/serdes_tx_fifo.sv
// Synchronous FIFO feeding the transmit serializer. Pushes are ignored when
// full and pops are ignored when empty.
module serdes_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serdes_tx_serializer.sv
// LSB-first parallel-to-serial transmitter with optional even parity and a
// first-bit strobe. Frames follow each other with no gap while data is queued.
module serdes_tx_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_EN  = 1,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx_out,
  output logic                          tx_frame,
  output logic                          tx_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned BW = $clog2(DATA_W + 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              parity_bit;
  logic              full;
  logic              empty;
  logic              pop;
  logic              frame_end;
  logic [DATA_W-1:0] head;

  serdes_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign s_ready = !full;

  // Pop whenever a new frame can be launched: from idle or at a frame's last bit.
  always_comb begin
    frame_end = 1'b0;
    case (state)
      ST_DATA:   frame_end = (bit_cnt == BW'(DATA_W)) && (PARITY_EN == 0);
      ST_PARITY: frame_end = 1'b1;
      default:   frame_end = 1'b0;
    endcase
    pop = ena && !empty && ((state == ST_IDLE) || frame_end);
  end

  // Launch, shift and parity sequencing; everything freezes while ena is low.
  // Frame launch is factored out of the per-state case since it is identical
  // from idle and at an end-of-frame with data queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
      tx_out     <= IDLE_LEVEL;
      tx_frame   <= 1'b0;
      tx_active  <= 1'b0;
    end else if (ena) begin
      tx_frame <= 1'b0;
      if (pop) begin
        shreg      <= head >> 1;
        parity_bit <= ^head;
        tx_out     <= head[0];
        tx_frame   <= 1'b1;
        tx_active  <= 1'b1;
        bit_cnt    <= BW'(1);
        state      <= ST_DATA;
      end else begin
        case (state)
          ST_DATA: begin
            if (bit_cnt != BW'(DATA_W)) begin
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BW'(1);
            end else if (PARITY_EN != 0) begin
              tx_out <= parity_bit;
              state  <= ST_PARITY;
            end else begin
              tx_out    <= IDLE_LEVEL;
              tx_active <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          ST_PARITY: begin
            tx_out    <= IDLE_LEVEL;
            tx_active <= 1'b0;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serdes_tx_serializer.sv
// Self-checking bench for serdes_tx_serializer with default parameters.
module tb_serdes_tx_serializer;

  localparam logic LVL = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       tx_out;
  logic       tx_frame;
  logic       tx_active;
  logic [2:0] fifo_count;

  int passed = 0;
  int total  = 0;

  serdes_tx_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .tx_out     (tx_out),
    .tx_frame   (tx_frame),
    .tx_active  (tx_active),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference frame: data bits LSB first, then a bit making the total ones even.
  function automatic logic [8:0] frame_bits(input logic [7:0] b);
    logic [8:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = b[i];
      ones += int'(b[i]);
    end
    f[8] = logic'(ones % 2);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    s_data  = b;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  // Steps through bit positions first..last of a frame comparing the line.
  task automatic observe_frame(input logic [7:0] b, input int first, input int last);
    logic [8:0] f;
    logic [2:0] exp;
    f = frame_bits(b);
    for (int i = first; i <= last; i++) begin
      step();
      exp = {f[i], (i == 0), 1'b1};
      total++;
      if ({tx_out, tx_frame, tx_active} !== exp)
        $display("FAIL frame_%02h_bit%0d: out/frame/active got %b expected %b", b, i,
                 {tx_out, tx_frame, tx_active}, exp);
      else passed++;
    end
  endtask

  task automatic check_idle(input string tag);
    step();
    total++;
    if ({tx_out, tx_frame, tx_active} !== {LVL, 2'b00})
      $display("FAIL %s_idle: out/frame/active got %b expected %b", tag,
               {tx_out, tx_frame, tx_active}, {LVL, 2'b00});
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({tx_out, tx_frame, tx_active, s_ready, fifo_count} !== {LVL, 2'b00, 1'b1, 3'd0})
      $display("FAIL reset_state: got %b expected %b",
               {tx_out, tx_frame, tx_active, s_ready, fifo_count}, {LVL, 2'b00, 1'b1, 3'd0});
    else passed++;
    repeat (2) step();
    rst_n = 1'b1;
    check_idle("post_reset");
  endtask

  task automatic test_ff();
    write_byte(8'hFF);
    observe_frame(8'hFF, 0, 8);
    check_idle("ff");
  endtask

  task automatic test_a5();
    total++;
    if (tx_active !== 1'b0) $display("FAIL a5_pre_active: got %b expected 0", tx_active);
    else passed++;
    write_byte(8'hA5);
    observe_frame(8'hA5, 0, 8);
    check_idle("a5");
  endtask

  task automatic test_back_to_back();
    s_data  = 8'h01;
    s_valid = 1'b1;
    step();
    s_data = 8'h80;
    step();
    s_valid = 1'b0;
    total++;
    if ({tx_out, tx_frame, tx_active} !== 3'b111)
      $display("FAIL b2b_first_bit: got %b expected 111", {tx_out, tx_frame, tx_active});
    else passed++;
    observe_frame(8'h01, 1, 8);
    observe_frame(8'h80, 0, 8);
    check_idle("b2b");
  endtask

  // Fill the FIFO with ena low, try one extra write, then release and drain.
  task automatic test_fill(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] q[$];
    q = '{b0, b1, b2, b3};
    ena = 1'b0;
    foreach (q[i]) write_byte(q[i]);
    total++;
    if ({fifo_count, s_ready} !== {3'd4, 1'b0})
      $display("FAIL fill_full: count/ready got %b expected %b", {fifo_count, s_ready}, {3'd4, 1'b0});
    else passed++;
    write_byte(8'hEE);
    total++;
    if (fifo_count !== 3'd4) $display("FAIL fill_overflow: count got %0d expected 4", fifo_count);
    else passed++;
    ena = 1'b1;
    while (q.size() > 0) observe_frame(q.pop_front(), 0, 8);
    total++;
    if (fifo_count !== 3'd0) $display("FAIL fill_drain: count got %0d expected 0", fifo_count);
    else passed++;
    check_idle("fill");
  endtask

  task automatic test_freeze();
    write_byte(8'hA5);
    observe_frame(8'hA5, 0, 3);
    ena = 1'b0;
    repeat (3) begin
      step();
      total++;
      if ({tx_out, tx_frame, tx_active} !== 3'b001)
        $display("FAIL freeze_hold: got %b expected 001", {tx_out, tx_frame, tx_active});
      else passed++;
    end
    ena = 1'b1;
    observe_frame(8'hA5, 4, 8);
    check_idle("freeze");
  endtask

  task automatic test_reset_mid();
    s_data  = 8'h3C;
    s_valid = 1'b1;
    step();
    s_data = 8'h5A;
    step();
    s_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({tx_out, tx_active, fifo_count} !== {LVL, 1'b0, 3'd0})
      $display("FAIL reset_mid_async: out/active/count got %b expected %b",
               {tx_out, tx_active, fifo_count}, {LVL, 1'b0, 3'd0});
    else passed++;
    step();
    rst_n = 1'b1;
    check_idle("reset_mid");
    write_byte(8'h3C);
    observe_frame(8'h3C, 0, 8);
    check_idle("reset_mid_3c");
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b;
    int n;
    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(1, 4);
      ena = 1'b0;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        write_byte(b);
      end
      total++;
      if (fifo_count !== 3'(n))
        $display("FAIL rand_count_%0d: got %0d expected %0d", it, fifo_count, n);
      else passed++;
      ena = 1'b1;
      while (q.size() > 0) observe_frame(q.pop_front(), 0, 8);
      check_idle("rand");
    end
  endtask

  initial begin
    test_reset();
    test_ff();
    test_a5();
    test_back_to_back();
    test_fill(8'h11, 8'h22, 8'h33, 8'h44);
    test_freeze();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
